fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction-fetch stage that owns the program counter and feeds the jump/branch stage downstream. It issues one instruction-memory request at a time, presents the fetched instruction and its PC to decode with a valid/ready handshake, and applies redirects computed downstream from the branch target address. In-flight responses made stale by a redirect are squashed.

## Interface
- XLEN, 32, address and data width
- RESET_VECTOR, 32'h0000_0000, PC value loaded on reset
- clk  in  1  system clock; all state updates on the rising edge
- reset  in  1  synchronous, active-high reset
- redirect_valid  in  1  redirect request; single-cycle pulse or level, sampled every cycle
- redirect_addr  in  XLEN  redirect target, driven by the jump/branch stage `address_out`
- imem_req_valid  out  1  instruction-memory request valid
- imem_req_addr  out  XLEN  request address; always the current PC
- imem_req_ready  in  1  memory accepts the request this cycle
- imem_resp_valid  in  1  response data valid; one response per accepted request
- imem_resp_data  in  XLEN  instruction word
- if_valid  out  1  fetched instruction valid toward decode
- if_pc  out  XLEN  PC of the presented instruction
- if_instr  out  XLEN  presented instruction
- if_ready  in  1  decode consumes the instruction this cycle
- misalign_err  out  1  sticky flag: a redirect target had bits [1:0] != 0

## Operation
- All outputs are registered except `imem_req_valid` and `imem_req_addr`, which are decoded from state and PC.
- Reset: pc=RESET_VECTOR, state=IDLE, squash=0, if_valid=0, if_pc=0, if_instr=0, misalign_err=0, imem_req_valid=0. Reset overrides every other input.
- IDLE: moves to REQ on the next cycle.
- REQ: imem_req_valid=1 and imem_req_addr=pc.
  - On imem_req_ready, move to WAIT.
  - On a redirect without req_ready: pc<=target and stay in REQ; the address changes on the next cycle.
  - On a redirect together with req_ready: the old address was accepted, so squash<=1, pc<=target, and move to WAIT.
- WAIT:
  - On imem_resp_valid with squash=1: discard the response, clear squash, move to REQ.
  - On imem_resp_valid with squash=0 and no redirect: if_instr<=resp_data, if_pc<=pc, if_valid<=1, move to HOLD.
  - On a redirect with no response: pc<=target, squash<=1, stay in WAIT.
  - On a redirect together with a response: discard the response, pc<=target, squash<=0, move to REQ.
- HOLD: if_valid=1 and the outputs are held stable.
  - On if_ready with no redirect: pc<=pc+4, if_valid<=0, move to REQ.
  - On a redirect, regardless of if_ready: pc<=target, if_valid<=0, move to REQ. The presented instruction is still counted as consumed if if_ready=1.
- Redirect target is {redirect_addr[XLEN-1:2], 2'b00}. If redirect_addr[1:0]!=0, misalign_err<=1, and it stays set until reset.
- Arithmetic: pc+4 is modulo 2^XLEN, so 32'hFFFF_FFFC wraps to 0 with no flag.
- At most one request is outstanding, and squash is never set while no request is outstanding.

## Timing
- Cycle 0 is the first cycle with reset low; state is IDLE.
- Zero-wait memory (req_ready=1, response on the cycle after acceptance): request in cycle 1, response in cycle 2, if_valid=1 in cycle 3.
- Steady-state throughput is one instruction per 3 cycles with if_ready held at 1.
- A redirect in HOLD produces the new request on the next cycle; the first redirected instruction reaches if_valid 3 cycles after the redirect, with zero-wait memory.
- A squashed redirect costs one extra memory round trip.
- if_pc, if_instr and if_valid must not change while if_valid=1 and if_ready=0, unless a redirect or reset occurs.

## Test plan
- Reset with RESET_VECTOR=32'h100, zero-wait memory, if_ready=1 -> if_pc sequence 0x100, 0x104, 0x108; first if_valid in cycle 3.
- if_ready=0 for 5 cycles in HOLD with instr=32'h00A00093 -> outputs stable for 5 cycles; pc advances only after if_ready rises.
- Redirect to 0x400 in WAIT, response arriving 3 cycles later -> old response dropped, next request address 0x400, if_pc=0x400.
- Redirect to 0x200 in the same cycle as req_ready in REQ -> squash set, the following response discarded, next request address 0x200.
- Redirect to 0x203 -> request address 0x200 and misalign_err=1, still set after 10 cycles; reset clears it.
- Assert reset in WAIT with a response pending -> next cycle if_valid=0, imem_req_valid=0, pc=RESET_VECTOR; a late response is ignored because the state is IDLE.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction fetch: owns the PC, keeps one imem request in flight, squashes responses made stale by redirects.
// Zero-wait memory gives if_valid 3 cycles after leaving IDLE; HOLD freezes the outputs until if_ready or a redirect.
module fetch_unit #(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_addr,
  output logic            imem_req_valid,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_req_ready,
  input  logic            imem_resp_valid,
  input  logic [XLEN-1:0] imem_resp_data,
  output logic            if_valid,
  output logic [XLEN-1:0] if_pc,
  output logic [XLEN-1:0] if_instr,
  input  logic            if_ready,
  output logic            misalign_err
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_HOLD
  } state_t;

  localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

  state_t          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            squash_q, squash_d;
  logic            valid_d;
  logic [XLEN-1:0] if_pc_d;
  logic [XLEN-1:0] instr_d;
  logic [XLEN-1:0] target;
  logic            target_misaligned;

  assign target            = {redirect_addr[XLEN-1:2], 2'b00};
  assign target_misaligned = redirect_valid && (redirect_addr[1:0] != 2'b00);

  assign imem_req_valid = (state_q == S_REQ);
  assign imem_req_addr  = pc_q;

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    squash_d = squash_q;
    valid_d  = if_valid;
    if_pc_d  = if_pc;
    instr_d  = if_instr;
    case (state_q)
      S_IDLE: begin
        state_d = S_REQ;
        if (redirect_valid) pc_d = target;
      end
      S_REQ: begin
        if (redirect_valid) pc_d = target;
        // A redirect in the accept cycle means the old address is already in flight.
        if (imem_req_ready) begin
          state_d  = S_WAIT;
          squash_d = redirect_valid;
        end
      end
      S_WAIT: begin
        if (imem_resp_valid) begin
          if (squash_q || redirect_valid) begin
            squash_d = 1'b0;
            state_d  = S_REQ;
            if (redirect_valid) pc_d = target;
          end else begin
            valid_d = 1'b1;
            if_pc_d = pc_q;
            instr_d = imem_resp_data;
            state_d = S_HOLD;
          end
        end else if (redirect_valid) begin
          pc_d     = target;
          squash_d = 1'b1;
        end
      end
      S_HOLD: begin
        if (redirect_valid) begin
          pc_d    = target;
          valid_d = 1'b0;
          state_d = S_REQ;
        end else if (if_ready) begin
          pc_d    = pc_q + PC_STEP;
          valid_d = 1'b0;
          state_d = S_REQ;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      pc_q         <= RESET_VECTOR;
      squash_q     <= 1'b0;
      if_valid     <= 1'b0;
      if_pc        <= '0;
      if_instr     <= '0;
      misalign_err <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      squash_q     <= squash_d;
      if_valid     <= valid_d;
      if_pc        <= if_pc_d;
      if_instr     <= instr_d;
      misalign_err <= misalign_err | target_misaligned;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed timing scenarios plus a randomized run against a PC-stream model
// with a latency-programmable single-request memory.
module tb_fetch_unit;
  localparam logic [31:0] RV = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        reset;
  logic        redirect_valid;
  logic [31:0] redirect_addr;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
  logic        if_ready;
  logic        misalign_err;

  always #5 clk = ~clk;

  fetch_unit #(.XLEN(32), .RESET_VECTOR(RV)) dut (
    .clk             (clk),
    .reset           (reset),
    .redirect_valid  (redirect_valid),
    .redirect_addr   (redirect_addr),
    .imem_req_valid  (imem_req_valid),
    .imem_req_addr   (imem_req_addr),
    .imem_req_ready  (imem_req_ready),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .if_valid        (if_valid),
    .if_pc           (if_pc),
    .if_instr        (if_instr),
    .if_ready        (if_ready),
    .misalign_err    (misalign_err)
  );

  int total = 0;
  int bad   = 0;

  // Memory model state
  logic        mem_auto;
  logic        pend;
  logic [31:0] pend_addr;
  int          pend_cnt;
  int          mem_lat;
  int          proto_err;
  logic        use_fixed;
  logic [31:0] fixed_data;

  // Values sampled on the falling edge, i.e. what the DUT sees at the next rising edge
  logic        s_if_valid, s_if_ready, s_redir, s_req_valid, s_req_ready, s_resp_valid, s_mis;
  logic [31:0] s_if_pc, s_if_instr, s_redir_addr, s_req_addr;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (use_fixed) return fixed_data;
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic tick();
    @(negedge clk);
    s_if_valid   = if_valid;
    s_if_ready   = if_ready;
    s_if_pc      = if_pc;
    s_if_instr   = if_instr;
    s_redir      = redirect_valid;
    s_redir_addr = redirect_addr;
    s_req_valid  = imem_req_valid;
    s_req_addr   = imem_req_addr;
    s_req_ready  = imem_req_ready;
    s_resp_valid = imem_resp_valid;
    s_mis        = misalign_err;
    @(posedge clk);
    #1;
    if (mem_auto) begin
      if (s_resp_valid) pend = 1'b0;
      if (s_req_valid && s_req_ready) begin
        if (pend) proto_err++;
        pend      = 1'b1;
        pend_addr = s_req_addr;
        pend_cnt  = mem_lat;
      end
      imem_resp_valid = 1'b0;
      if (pend) begin
        if (pend_cnt == 0) begin
          imem_resp_valid = 1'b1;
          imem_resp_data  = mem_word(pend_addr);
        end else begin
          pend_cnt--;
        end
      end
    end
  endtask

  // Leaves the bench in cycle 0 (first cycle with reset low)
  task automatic do_reset();
    reset           = 1'b1;
    redirect_valid  = 1'b0;
    redirect_addr   = '0;
    imem_req_ready  = 1'b1;
    imem_resp_valid = 1'b0;
    imem_resp_data  = '0;
    if_ready        = 1'b1;
    mem_auto        = 1'b1;
    pend            = 1'b0;
    pend_cnt        = 0;
    mem_lat         = 0;
    use_fixed       = 1'b0;
    fixed_data      = '0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] exp_pc;
    do_reset();
    total++;
    if ({if_valid, imem_req_valid, misalign_err} !== 3'b000) begin
      bad++;
      $display("FAIL reset_flags: got v=%b req=%b mis=%b want 0 0 0", if_valid, imem_req_valid, misalign_err);
    end
    total++;
    if ({if_pc, if_instr} !== 64'h0) begin
      bad++;
      $display("FAIL reset_regs: got pc=%h instr=%h want 0 0", if_pc, if_instr);
    end
    for (int c = 1; c <= 9; c++) begin
      tick();
      if (c == 1) begin
        total++;
        if ({imem_req_valid, imem_req_addr} !== {1'b1, RV}) begin
          bad++;
          $display("FAIL first_req: got v=%b addr=%h want 1 %h", imem_req_valid, imem_req_addr, RV);
        end
      end
      total++;
      if (if_valid !== (c % 3 == 0)) begin
        bad++;
        $display("FAIL seq_valid cycle %0d: got %b want %b", c, if_valid, (c % 3 == 0));
      end
      if (c % 3 == 0) begin
        exp_pc = RV + 32'(4 * (c / 3 - 1));
        total++;
        if ({if_pc, if_instr} !== {exp_pc, mem_word(exp_pc)}) begin
          bad++;
          $display("FAIL seq_pc cycle %0d: got pc=%h instr=%h want %h %h", c, if_pc, if_instr, exp_pc, mem_word(exp_pc));
        end
      end
    end
  endtask

  task automatic test_stall();
    do_reset();
    use_fixed  = 1'b1;
    fixed_data = 32'h00A0_0093;
    if_ready   = 1'b0;
    repeat (3) tick();
    total++;
    if ({if_valid, if_pc, if_instr} !== {1'b1, RV, 32'h00A0_0093}) begin
      bad++;
      $display("FAIL stall_enter: got v=%b pc=%h instr=%h want 1 %h 00a00093", if_valid, if_pc, if_instr, RV);
    end
    for (int k = 0; k < 5; k++) begin
      tick();
      total++;
      if ({if_valid, if_pc, if_instr, imem_req_valid} !== {1'b1, RV, 32'h00A0_0093, 1'b0}) begin
        bad++;
        $display("FAIL stall_hold %0d: got v=%b pc=%h instr=%h req=%b want 1 %h 00a00093 0", k, if_valid, if_pc, if_instr, imem_req_valid, RV);
      end
    end
    if_ready = 1'b1;
    tick();
    total++;
    if ({if_valid, imem_req_valid, imem_req_addr} !== {1'b0, 1'b1, RV + 32'd4}) begin
      bad++;
      $display("FAIL stall_release: got v=%b req=%b addr=%h want 0 1 %h", if_valid, imem_req_valid, imem_req_addr, RV + 32'd4);
    end
    use_fixed = 1'b0;
  endtask

  task automatic test_redirect_wait();
    do_reset();
    mem_lat = 3;
    tick();
    tick();
    redirect_valid = 1'b1;
    redirect_addr  = 32'h0000_0400;
    tick();
    redirect_valid = 1'b0;
    mem_lat        = 0;
    for (int c = 3; c <= 5; c++) begin
      total++;
      if ({imem_req_valid, if_valid} !== 2'b00) begin
        bad++;
        $display("FAIL rw_squash cycle %0d: got req=%b v=%b want 0 0", c, imem_req_valid, if_valid);
      end
      tick();
    end
    total++;
    if ({imem_req_valid, imem_req_addr} !== {1'b1, 32'h0000_0400}) begin
      bad++;
      $display("FAIL rw_newreq: got v=%b addr=%h want 1 00000400", imem_req_valid, imem_req_addr);
    end
    tick();
    tick();
    total++;
    if ({if_valid, if_pc, if_instr} !== {1'b1, 32'h0000_0400, mem_word(32'h0000_0400)}) begin
      bad++;
      $display("FAIL rw_deliver: got v=%b pc=%h instr=%h want 1 00000400 %h", if_valid, if_pc, if_instr, mem_word(32'h0000_0400));
    end
  endtask

  task automatic test_redirect_req();
    do_reset();
    tick();
    redirect_valid = 1'b1;
    redirect_addr  = 32'h0000_0200;
    tick();
    redirect_valid = 1'b0;
    total++;
    if ({imem_req_valid, if_valid} !== 2'b00) begin
      bad++;
      $display("FAIL rq_wait: got req=%b v=%b want 0 0", imem_req_valid, if_valid);
    end
    tick();
    total++;
    if ({imem_req_valid, imem_req_addr, if_valid} !== {1'b1, 32'h0000_0200, 1'b0}) begin
      bad++;
      $display("FAIL rq_newreq: got req=%b addr=%h v=%b want 1 00000200 0", imem_req_valid, imem_req_addr, if_valid);
    end
    tick();
    tick();
    total++;
    if ({if_valid, if_pc, if_instr} !== {1'b1, 32'h0000_0200, mem_word(32'h0000_0200)}) begin
      bad++;
      $display("FAIL rq_deliver: got v=%b pc=%h instr=%h want 1 00000200 %h", if_valid, if_pc, if_instr, mem_word(32'h0000_0200));
    end
  endtask

  task automatic test_misalign();
    do_reset();
    if_ready = 1'b0;
    repeat (3) tick();
    redirect_valid = 1'b1;
    redirect_addr  = 32'h0000_0203;
    tick();
    redirect_valid = 1'b0;
    total++;
    if ({imem_req_valid, imem_req_addr, misalign_err, if_valid} !== {1'b1, 32'h0000_0200, 1'b1, 1'b0}) begin
      bad++;
      $display("FAIL mis_redirect: got req=%b addr=%h mis=%b v=%b want 1 00000200 1 0", imem_req_valid, imem_req_addr, misalign_err, if_valid);
    end
    if_ready = 1'b1;
    repeat (10) tick();
    total++;
    if (misalign_err !== 1'b1) begin
      bad++;
      $display("FAIL mis_sticky: got %b want 1", misalign_err);
    end
    do_reset();
    total++;
    if (misalign_err !== 1'b0) begin
      bad++;
      $display("FAIL mis_clear: got %b want 0", misalign_err);
    end
  endtask

  task automatic test_reset_wait();
    do_reset();
    mem_auto = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    tick();
    total++;
    if ({if_valid, imem_req_valid, imem_req_addr} !== {1'b0, 1'b0, RV}) begin
      bad++;
      $display("FAIL rst_wait: got v=%b req=%b pc=%h want 0 0 %h", if_valid, imem_req_valid, imem_req_addr, RV);
    end
    reset           = 1'b0;
    imem_resp_valid = 1'b1;
    imem_resp_data  = 32'hDEAD_BEEF;
    tick();
    imem_resp_valid = 1'b0;
    total++;
    if ({if_valid, imem_req_valid, imem_req_addr} !== {1'b0, 1'b1, RV}) begin
      bad++;
      $display("FAIL rst_late_resp: got v=%b req=%b addr=%h want 0 1 %h", if_valid, imem_req_valid, imem_req_addr, RV);
    end
    tick();
    imem_resp_valid = 1'b1;
    imem_resp_data  = 32'h1111_2222;
    tick();
    imem_resp_valid = 1'b0;
    total++;
    if ({if_valid, if_pc, if_instr} !== {1'b1, RV, 32'h1111_2222}) begin
      bad++;
      $display("FAIL rst_refetch: got v=%b pc=%h instr=%h want 1 %h 11112222", if_valid, if_pc, if_instr, RV);
    end
    mem_auto = 1'b1;
  endtask

  task automatic test_random();
    logic [31:0] exp_pc, pc_prev, instr_prev;
    logic        exp_mis, hold_prev;
    int          delivered;
    do_reset();
    exp_pc    = RV;
    exp_mis   = 1'b0;
    hold_prev = 1'b0;
    delivered = 0;
    proto_err = 0;
    pc_prev   = '0;
    instr_prev = '0;
    for (int i = 0; i < 3000; i++) begin
      if_ready       = ($urandom_range(0, 3) != 0);
      imem_req_ready = ($urandom_range(0, 3) != 0);
      mem_lat        = $urandom_range(0, 2);
      redirect_valid = (i > 0) && ($urandom_range(0, 11) == 0);
      case ($urandom_range(0, 7))
        0:       redirect_addr = 32'hFFFF_FFFC;
        1:       redirect_addr = $urandom_range(0, 32'h3FFF);
        default: redirect_addr = $urandom & 32'h0000_3FFC;
      endcase
      tick();
      if (hold_prev) begin
        total++;
        if ({s_if_valid, s_if_pc, s_if_instr} !== {1'b1, pc_prev, instr_prev}) begin
          bad++;
          $display("FAIL rnd_stable %0d: got v=%b pc=%h instr=%h want 1 %h %h", i, s_if_valid, s_if_pc, s_if_instr, pc_prev, instr_prev);
        end
      end
      if (s_if_valid) begin
        total++;
        if ({s_if_pc, s_if_instr} !== {exp_pc, mem_word(exp_pc)}) begin
          bad++;
          $display("FAIL rnd_stream %0d: got pc=%h instr=%h want %h %h", i, s_if_pc, s_if_instr, exp_pc, mem_word(exp_pc));
        end
      end
      total++;
      if (s_mis !== exp_mis) begin
        bad++;
        $display("FAIL rnd_misalign %0d: got %b want %b", i, s_mis, exp_mis);
      end
      hold_prev  = s_if_valid && !s_if_ready && !s_redir;
      pc_prev    = s_if_pc;
      instr_prev = s_if_instr;
      if (s_if_valid && s_if_ready) delivered++;
      if (s_redir) begin
        exp_pc = s_redir_addr & 32'hFFFF_FFFC;
        if (s_redir_addr[1:0] != 2'b00) exp_mis = 1'b1;
      end else if (s_if_valid && s_if_ready) begin
        exp_pc = exp_pc + 32'd4;
      end
    end
    redirect_valid = 1'b0;
    total++;
    if (delivered < 100) begin
      bad++;
      $display("FAIL rnd_progress: got %0d deliveries want >= 100", delivered);
    end
    total++;
    if (proto_err != 0) begin
      bad++;
      $display("FAIL rnd_outstanding: got %0d overlapping requests want 0", proto_err);
    end
  endtask

  initial begin
    proto_err = 0;
    test_reset();
    test_stall();
    test_redirect_wait();
    test_redirect_req();
    test_misalign();
    test_reset_wait();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
